inst_fetch_unit: RTL and testbench

- Reader side of the simple CPU's instruction memory. Owns the program counter (PC) and drives the byte address into instruction memory.
- Instruction memory read is combinational: the word for `imem_addr` is valid in the same cycle.
- Captures {pc, instruction} pairs into a 2-entry fetch queue, which feeds decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush the queue and reload the PC.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/inst_fetch_unit_if.sv | 31 +++
 rtl/fetch_queue.sv | 53 +++++
 rtl/inst_fetch_unit.sv | 82 ++++++++
 tb/tb_inst_fetch_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Provides widths, the PC step and the fetch queue entry type.
package cpu_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
   localparam int IMEM_WORDS_DEFAULT = 64;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus: imem read port, redirect, decode handshake, fault.
// master = fetch unit side, slave = memory/decode/execute side.
interface inst_fetch_unit_if;
   import cpu_pkg::*;

   logic              fetch_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [INST_W-1:0] imem_inst;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              fetch_fault;

   modport master (
      input  fetch_en, imem_inst, redirect_valid,
      input  redirect_pc, inst_ready,
      output imem_addr, inst_valid, inst, inst_pc,
      output fetch_fault
   );

   modport slave (
      output fetch_en, imem_inst, redirect_valid,
      output redirect_pc, inst_ready,
      input  imem_addr, inst_valid, inst, inst_pc,
      input  fetch_fault
   );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of {pc, inst} pairs.
// Ports: clk, rst, push, pop, flush, din, dout, count.
module fetch_queue
   import cpu_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  logic      flush,
   input  fq_entry_t din,
   output fq_entry_t dout,
   output logic [1:0] count
);

   fq_entry_t mem [2];
   fq_entry_t last;
   logic      wr_ptr;
   logic      rd_ptr;

   // When empty, show the entry most recently handed to decode.
   assign dout = (count != 2'd0) ? mem[rd_ptr] : last;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '{pc: '0, inst: NOP_INST};
         mem[1] <= '{pc: '0, inst: NOP_INST};
         last   <= '{pc: '0, inst: NOP_INST};
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            last   <= mem[rd_ptr];
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC register, imem address, 2-deep fetch queue.
// Ports: clk, rst, bus (master: imem, redirect, decode, fetch_fault).
// Optional IMEM_BOUND_CHECK_EN: sticky fault on fetch past IMEM_WORDS.
module inst_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                IMEM_WORDS = IMEM_WORDS_DEFAULT,
   parameter int                QDEPTH     = 2
) (
   input logic clk,
   input logic rst,
   inst_fetch_unit_if.master bus
);

`ifdef IMEM_BOUND_CHECK_EN
   localparam bit BOUND_EN = 1'b1;
`else
   localparam bit BOUND_EN = 1'b0;
`endif

   localparam logic [1:0] QMAX = 2'(QDEPTH);

   logic [ADDR_W-1:0] pc;
   logic              fault;
   logic [1:0]        count;
   logic              redir;
   logic              pop;
   logic              try_fetch;
   logic              oob;
   logic              push;
   fq_entry_t         head;
   logic              unused_lsb;

   assign redir = bus.redirect_valid;
   assign bus.inst_valid = (count != 2'd0);

   // Redirect overrides both queue operations.
   assign pop = bus.inst_valid & bus.inst_ready & ~redir;

   assign try_fetch = bus.fetch_en & ~redir & ~fault
                    & ((count < QMAX) | pop);

   assign oob = BOUND_EN
              && ({2'b00, pc[ADDR_W-1:2]} >= 32'(IMEM_WORDS));

   assign push = try_fetch & ~oob;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         fault <= 1'b0;
      end else if (redir) begin
         pc    <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
         fault <= 1'b0;
      end else begin
         if (push)
            pc <= pc + PC_STEP;
         if (try_fetch & oob)
            fault <= 1'b1;
      end
   end

   fetch_queue u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redir),
      .din   ('{pc: pc, inst: bus.imem_inst}),
      .dout  (head),
      .count (count)
   );

   assign bus.imem_addr   = pc;
   assign bus.inst        = head.inst;
   assign bus.inst_pc     = head.pc;
   assign bus.fetch_fault = fault;

   assign unused_lsb = ^bus.redirect_pc[1:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; memory word k = 1000_0000 + k.
// Checks are taken 1 time unit after each rising clock edge.
module tb_inst_fetch_unit;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;

   inst_fetch_unit_if bus ();

   inst_fetch_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_inst = 32'h1000_0000 + {2'b00, bus.imem_addr[31:2]};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
      chk({tag, "_inst"}, bus.inst, 32'h0);
      chk({tag, "_pc"}, bus.inst_pc, 32'h0);
      chk({tag, "_addr"}, bus.imem_addr, 32'h0);
      chk({tag, "_fault"}, 32'(bus.fetch_fault), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus.fetch_en = 1'b1;
      bus.inst_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;

      step();
      chk_reset("rst0");

      rst = 1'b0;
      step();
      chk("cap0_valid", 32'(bus.inst_valid), 32'd1);
      chk("cap0_inst", bus.inst, 32'h1000_0000);
      chk("cap0_pc", bus.inst_pc, 32'h0);
      chk("cap0_addr", bus.imem_addr, 32'h4);
      step();
      chk("cap1_inst", bus.inst, 32'h1000_0001);
      chk("cap1_pc", bus.inst_pc, 32'h4);
      step();
      chk("cap2_inst", bus.inst, 32'h1000_0002);
      chk("cap2_pc", bus.inst_pc, 32'h8);
      chk("cap2_addr", bus.imem_addr, 32'hC);

      rst = 1'b1;
      step();
      chk_reset("rst1");

      rst = 1'b0;
      bus.inst_ready = 1'b0;
      repeat (4) step();
      chk("full_addr", bus.imem_addr, 32'h8);
      chk("full_valid", 32'(bus.inst_valid), 32'd1);
      chk("full_head", bus.inst_pc, 32'h0);
      chk("full_inst", bus.inst, 32'h1000_0000);

      bus.inst_ready = 1'b1;
      step();
      chk("drain1_pc", bus.inst_pc, 32'h4);
      chk("drain1_inst", bus.inst, 32'h1000_0001);
      chk("drain1_addr", bus.imem_addr, 32'hC);
      step();
      chk("drain2_pc", bus.inst_pc, 32'h8);
      chk("drain2_valid", 32'(bus.inst_valid), 32'd1);

      bus.inst_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_0023;
      step();
      chk("redir_valid", 32'(bus.inst_valid), 32'd0);
      chk("redir_addr", bus.imem_addr, 32'h20);
      chk("redir_hold_pc", bus.inst_pc, 32'h4);

      bus.redirect_valid = 1'b0;
      step();
      chk("tgt_valid", 32'(bus.inst_valid), 32'd1);
      chk("tgt_pc", bus.inst_pc, 32'h20);
      chk("tgt_inst", bus.inst, 32'h1000_0008);
      step();
      chk("tgt_full_pc", bus.inst_pc, 32'h20);
      chk("tgt_full_addr", bus.imem_addr, 32'h28);

      bus.inst_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_0040;
      step();
      chk("rp_valid", 32'(bus.inst_valid), 32'd0);
      chk("rp_addr", bus.imem_addr, 32'h40);
      chk("rp_hold_pc", bus.inst_pc, 32'h4);

      bus.redirect_valid = 1'b0;
      step();
      chk("rp_first_pc", bus.inst_pc, 32'h40);
      chk("rp_first_valid", 32'(bus.inst_valid), 32'd1);
      step();
      chk("rp_second_pc", bus.inst_pc, 32'h44);

      bus.fetch_en = 1'b0;
      step();
      chk("fen0_valid", 32'(bus.inst_valid), 32'd0);
      chk("fen0_hold_pc", bus.inst_pc, 32'h44);
      chk("fen0_addr", bus.imem_addr, 32'h48);
      step();
      chk("fen0b_addr", bus.imem_addr, 32'h48);

      bus.fetch_en = 1'b1;
      step();
      chk("fen1_pc", bus.inst_pc, 32'h48);
      chk("fen1_valid", 32'(bus.inst_valid), 32'd1);

`ifdef IMEM_BOUND_CHECK_EN
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_00F8;
      step();
      chk("bnd_addr", bus.imem_addr, 32'hF8);
      bus.redirect_valid = 1'b0;
      step();
      chk("bnd_f8", bus.inst_pc, 32'hF8);
      step();
      chk("bnd_fc", bus.inst_pc, 32'hFC);
      chk("bnd_nofault", 32'(bus.fetch_fault), 32'd0);
      step();
      chk("bnd_fault", 32'(bus.fetch_fault), 32'd1);
      chk("bnd_empty", 32'(bus.inst_valid), 32'd0);
      chk("bnd_addr100", bus.imem_addr, 32'h100);
      chk("bnd_hold_pc", bus.inst_pc, 32'hFC);
      step();
      chk("bnd_sticky", 32'(bus.fetch_fault), 32'd1);
      chk("bnd_no100", 32'(bus.inst_valid), 32'd0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0;
      step();
      chk("bnd_clear", 32'(bus.fetch_fault), 32'd0);
      bus.redirect_valid = 1'b0;
      step();
      chk("bnd_restart", bus.inst_pc, 32'h0);
      chk("bnd_restart_v", 32'(bus.inst_valid), 32'd1);
`else
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      step();
      chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
      chk("wrap_valid0", 32'(bus.inst_valid), 32'd0);
      bus.redirect_valid = 1'b0;
      step();
      chk("wrap_top_pc", bus.inst_pc, 32'hFFFF_FFFC);
      chk("wrap_top_inst", bus.inst, 32'h4FFF_FFFF);
      chk("wrap_addr0", bus.imem_addr, 32'h0);
      step();
      chk("wrap_zero_pc", bus.inst_pc, 32'h0);
      chk("wrap_zero_inst", bus.inst, 32'h1000_0000);
      chk("wrap_fault", 32'(bus.fetch_fault), 32'd0);
`endif

      rst = 1'b1;
      step();
      chk_reset("rst2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
